// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the FIFO-drain UART
//                transmitter. Holds the transmitter state encoding, the data
//                bits per frame and a helper that returns the frame length.
//  Config      : FIFO_UART_TX_PARITY_EN adds an even-parity bit per frame
//                (PARITY state, 11-bit frame). Undefined: plain 8N1.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Data bits carried by every UART frame.
  localparam int UART_DATA_BITS = 8;

  // Transmitter state encoding. PARITY only exists in the parity build so
  // that the default build carries no parity state or parity logic.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_t;

  // Bits per frame on the line: start + 8 data (+ parity) + stop.
  function automatic int frame_bits();
`ifdef FIFO_UART_TX_PARITY_EN
    return 11;
`else
    return 10;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_counter.sv
`default_nettype none
// ============================================================================
//  Module      : baud_counter
//  Description : Bit-period timer for the UART transmitter. Counts
//                0..CLKS_PER_BIT-1 and pulses bit_done on the final cycle of
//                each bit period, then wraps to 0 so the next bit starts
//                aligned. restart holds the count at 0 while the
//                transmitter is idle.
//  Ports       : clk      in   system clock (rising edge)
//                rst_n    in   synchronous active-low reset
//                restart  in   hold counter at 0 (transmitter idle)
//                bit_done out  high on the last cycle of a bit period
//  Revision    : 1.0  initial release
// ============================================================================
module baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Every state or bit change in the transmitter happens on bit_done, so the
  // wrap to 0 here doubles as the reload at each bit boundary.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign bit_done = !restart && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Drain stage for a show-ahead FIFO. Pops one WIDTH-bit word
//                whenever the FIFO is non-empty and sends it as WIDTH/8 UART
//                frames, least-significant byte first, LSB first within a
//                byte, with no idle time between the bytes of one word.
//  Config      : FIFO_UART_TX_PARITY_EN -> even parity bit after the data
//                bits (11-bit frame). Undefined -> 8N1 (10-bit frame).
//  Ports       : clk         in   system clock (rising edge)
//                rst_n       in   synchronous active-low reset
//                fifo_data   in   FIFO head word, valid when !fifo_empty
//                fifo_empty  in   FIFO empty flag
//                fifo_read   out  one-cycle pop strobe (combinational)
//                tx          out  serial line, idles high (registered)
//                busy        out  word in flight (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_read,
  output logic             tx,
  output logic             busy
);

  localparam int c_NBYTES = WIDTH / 8;
  localparam int c_BYTE_W = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
  localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(c_NBYTES - 1);
  localparam logic [2:0] c_LAST_BIT = 3'(UART_DATA_BITS - 1);

  // Elaboration-time parameter sanity checks.
  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("fifo_uart_tx: WIDTH must be a non-zero multiple of 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
  end

  tx_state_t             r_state;
  tx_state_t             w_state_next;
  logic [WIDTH-1:0]      r_word;
  logic [c_BYTE_W-1:0]   r_byte_idx;
  logic [c_BYTE_W-1:0]   w_byte_idx_next;
  logic [2:0]            r_bit_idx;
  logic [2:0]            w_bit_idx_next;
  logic                  w_load;
  logic                  w_bit_done;
  logic                  w_restart;
  logic [7:0]            w_cur_byte;
  logic                  w_tx_next;
  logic                  w_busy_next;
  logic                  r_tx;
  logic                  r_busy;

  // --------------------------------------------------------------------------
  // Bit timing. Held at zero while idle so the start bit of a freshly
  // captured word gets a full CLKS_PER_BIT cycles.
  // --------------------------------------------------------------------------
  assign w_restart = (r_state == IDLE);

  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (w_restart),
    .bit_done (w_bit_done)
  );

  // Pop and capture share one edge: the FIFO head is combinational, so the
  // word seen now is the word removed by this strobe.
  assign fifo_read = rst_n && (r_state == IDLE) && !fifo_empty;

  // --------------------------------------------------------------------------
  // Next-state and index logic.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_byte_idx_next = r_byte_idx;
    w_bit_idx_next  = r_bit_idx;
    w_load          = 1'b0;

    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_load          = 1'b1;
          w_byte_idx_next = '0;
          w_state_next    = START;
        end
      end

      START: begin
        if (w_bit_done) begin
          w_bit_idx_next = '0;
          w_state_next   = DATA;
        end
      end

      DATA: begin
        if (w_bit_done) begin
          if (r_bit_idx == c_LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_state_next = STOP;
        end
      end
`endif

      STOP: begin
        if (w_bit_done) begin
          if (r_byte_idx == c_LAST_BYTE) begin
            w_state_next = IDLE;
          end else begin
            w_byte_idx_next = r_byte_idx + c_BYTE_W'(1);
            w_state_next    = START;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Byte selection for the line value that will be driven next cycle. It
  // uses the next byte index so tx can be registered without a cycle of lag.
  // On the capture edge the word register is not yet loaded, but the next
  // state is START there, so the stale contents are never put on the line.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cur_byte = r_word[7:0];
    for (int i = 0; i < c_NBYTES; i++) begin
      if (w_byte_idx_next == c_BYTE_W'(i)) begin
        w_cur_byte = r_word[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_cur_byte[w_bit_idx_next];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  w_tx_next = ^w_cur_byte;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  assign w_busy_next = (w_state_next != IDLE);

  // --------------------------------------------------------------------------
  // State, word register and registered outputs. A reset mid-word drops the
  // captured word; it was already popped, so it is not re-read.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_word     <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_byte_idx <= w_byte_idx_next;
      r_bit_idx  <= w_bit_idx_next;
      if (w_load) begin
        r_word <= fifo_data;
      end
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Directed self-checking bench for fifo_uart_tx with
//                WIDTH=16, CLKS_PER_BIT=4. A small array-based FIFO model
//                feeds the DUT; expected line values come from hand-written
//                frames and a frame-bit model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int W_CYC = 2 * F * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read;
  logic        tx;
  logic        busy;

  logic [15:0] mem [0:15];
  logic [3:0]  head = '0;
  logic [3:0]  tail = '0;
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_data = 16'h5555;
  int          rd_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (head == tail);
  assign fifo_data  = ovr_en ? ovr_data : mem[head];

  always @(posedge clk) begin
    if (fifo_read) begin
      rd_cnt <= rd_cnt + 1;
      if (head != tail) head <= head + 4'd1;
    end
  end

  fifo_uart_tx #(
    .WIDTH        (16),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .tx         (tx),
    .busy       (busy)
  );

  task automatic push(input logic [15:0] w);
    mem[tail] = w;
    tail = tail + 4'd1;
  endtask

  // Expected line value k cycles after the capture edge (k=0 is the first
  // cycle of the start bit of byte 0).
  function automatic logic frame_bit(input logic [15:0] w, input int k);
    int bitpos, bidx, j;
    logic [7:0] b;
    bitpos = k / CPB;
    bidx   = bitpos / F;
    j      = bitpos % F;
    b      = (bidx == 0) ? w[7:0] : w[15:8];
    if (j == 0) return 1'b0;
    else if (j <= 8) return b[j-1];
`ifdef FIFO_UART_TX_PARITY_EN
    else if (j == 9) return ^b;
`endif
    else return 1'b1;
  endfunction

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    push(16'h1234);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (fifo_read !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_state rd=%b tx=%b busy=%b expected rd=0 tx=1 busy=0", fifo_read, tx, busy);
      end
    end
    checks++;
    if (rd_cnt !== 0) begin
      errors++;
      $display("FAIL reset_no_pop pops=%0d expected 0", rd_cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (fifo_read !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_pop rd=%b expected 1", fifo_read);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0 || rd_cnt !== 1) begin
      errors++;
      $display("FAIL reset_first_capture busy=%b tx=%b pops=%0d expected busy=1 tx=0 pops=1", busy, tx, rd_cnt);
    end
    n = 0;
    while (busy !== 1'b0 && n < W_CYC + 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_word_timeout busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single_word();
    int n, rd0;
    logic exp_bit;
    logic [19:0] hand;
    hand = 20'b0010110101_0101001011;
    @(negedge clk);
    push(16'hA55A);
    #1;
    n = 0;
    while (fifo_read !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fifo_read !== 1'b1) begin
      errors++;
      $display("FAIL single_pop_timeout rd=%b expected 1", fifo_read);
    end
    rd0 = rd_cnt;
    for (int k = 0; k < W_CYC; k++) begin
      @(negedge clk);
`ifdef FIFO_UART_TX_PARITY_EN
      exp_bit = frame_bit(16'hA55A, k);
`else
      exp_bit = hand[19 - k/CPB];
`endif
      checks++;
      if (tx !== exp_bit || busy !== 1'b1 || fifo_read !== 1'b0) begin
        errors++;
        $display("FAIL single_frame cyc=%0d tx=%b busy=%b rd=%b expected tx=%b busy=1 rd=0", k, tx, busy, fifo_read, exp_bit);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_end busy=%b tx=%b expected busy=0 tx=1", busy, tx);
    end
    checks++;
    if (rd_cnt - rd0 !== 1) begin
      errors++;
      $display("FAIL single_pop_count pops=%0d expected 1", rd_cnt - rd0);
    end
  endtask

  task automatic test_back_to_back();
    int n, rd0;
    logic exp_bit;
    @(negedge clk);
    push(16'h0001);
    push(16'hFFFF);
    #1;
    n = 0;
    while (fifo_read !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fifo_read !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pop_timeout rd=%b expected 1", fifo_read);
    end
    rd0 = rd_cnt;
    for (int k = 0; k <= 2 * W_CYC; k++) begin
      @(negedge clk);
      checks++;
      if (k < W_CYC) begin
        exp_bit = frame_bit(16'h0001, k);
        if (tx !== exp_bit || busy !== 1'b1 || fifo_read !== 1'b0) begin
          errors++;
          $display("FAIL b2b_word0 cyc=%0d tx=%b busy=%b rd=%b expected tx=%b busy=1 rd=0", k, tx, busy, fifo_read, exp_bit);
        end
      end else if (k == W_CYC) begin
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap cyc=%0d tx=%b busy=%b rd=%b expected tx=1 busy=0 rd=1", k, tx, busy, fifo_read);
        end
      end else begin
        exp_bit = frame_bit(16'hFFFF, k - W_CYC - 1);
        if (tx !== exp_bit || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_word1 cyc=%0d tx=%b busy=%b expected tx=%b busy=1", k, tx, busy, exp_bit);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || rd_cnt - rd0 !== 2) begin
      errors++;
      $display("FAIL b2b_end busy=%b tx=%b pops=%0d expected busy=0 tx=1 pops=2", busy, tx, rd_cnt - rd0);
    end
  endtask

  task automatic test_empty_idle();
    ovr_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ovr_data = ~ovr_data ^ 16'(i);
      #1;
      checks++;
      if (fifo_read !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle cyc=%0d rd=%b tx=%b busy=%b expected rd=0 tx=1 busy=0", i, fifo_read, tx, busy);
      end
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int n, rd0;
    @(negedge clk);
    push(16'hC3A5);
    #1;
    n = 0;
    while (fifo_read !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fifo_read !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pop_timeout rd=%b expected 1", fifo_read);
    end
    rd0 = rd_cnt;
    // k=49 lies inside the byte-1 data bits.
    for (int k = 0; k < 50; k++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_flight busy=%b expected 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after tx=%b busy=%b rd=%b expected tx=1 busy=0 rd=0", tx, busy, fifo_read);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet cyc=%0d tx=%b busy=%b rd=%b expected tx=1 busy=0 rd=0", i, tx, busy, fifo_read);
      end
    end
    checks++;
    if (rd_cnt - rd0 !== 1) begin
      errors++;
      $display("FAIL midrst_no_reread pops=%0d expected 1", rd_cnt - rd0);
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    int n, busy_cyc;
    @(negedge clk);
    push(16'h0107);
    #1;
    n = 0;
    while (fifo_read !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fifo_read !== 1'b1) begin
      errors++;
      $display("FAIL parity_pop_timeout rd=%b expected 1", fifo_read);
    end
    busy_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      // Parity slots: byte0 at bit 9 (cycles 36..39), byte1 at 80..83.
      if ((k >= 36 && k < 40) || (k >= 80 && k < 84)) begin
        checks++;
        if (tx !== 1'b1) begin
          errors++;
          $display("FAIL parity_bit cyc=%0d tx=%b expected 1", k, tx);
        end
      end
    end
    checks++;
    if (busy_cyc !== 88) begin
      errors++;
      $display("FAIL parity_busy_len cycles=%0d expected 88", busy_cyc);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_empty_idle();
    test_reset_mid_frame();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
